// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU), one restoring step per cycle.
// Optional macro FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  ZERO_N   = {N{1'b0}};
    localparam logic [N-1:0]  ONES_N   = {N{1'b1}};
    localparam logic [N-1:0]  MIN_N    = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [N-1:0] neg2(input logic [N-1:0] x);
        return ~x + ONE_N;
    endfunction

    state_t        state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [N-1:0]  rem_r, rem_n;
    logic [N-1:0]  quot_r, quot_n;
    logic [N-1:0]  dvsr_r, dvsr_n;
    logic          rem_sel_r, rem_sel_n;
    logic          neg_q_r, neg_q_n;
    logic          neg_rm_r, neg_rm_n;
    logic          special_r, special_n;
    logic [N-1:0]  special_val_r, special_val_n;
    logic [N-1:0]  result_r, result_n;
    logic          busy_r, done_r;

    logic          signed_s, a_neg_s, b_neg_s, div0_s, ovf_s, special_s;
    logic [N-1:0]  a_mag_s, b_mag_s, spec_val_s;
    logic [N:0]    shift_s, trial_s;
    logic [N-1:0]  step_rem_s, step_quot_s, final_s;

    // Start-time decode: magnitudes, signs and the RISC-V special-case value.
    always_comb begin
        signed_s   = ~op[0];
        a_neg_s    = signed_s & dividend[N-1];
        b_neg_s    = signed_s & divisor[N-1];
        a_mag_s    = a_neg_s ? neg2(dividend) : dividend;
        b_mag_s    = b_neg_s ? neg2(divisor) : divisor;
        div0_s     = (divisor == ZERO_N);
        ovf_s      = signed_s & (dividend == MIN_N) & (divisor == ONES_N);
        special_s  = div0_s | ovf_s;
        if (div0_s) begin
            spec_val_s = op[1] ? dividend : ONES_N;
        end else begin
            spec_val_s = op[1] ? ZERO_N : dividend;
        end
    end

    // One restoring step; the working remainder is N+1 bits wide, but the
    // stored remainder is always below the divisor and so fits in N bits.
    always_comb begin
        shift_s = {rem_r, quot_r[N-1]};
        trial_s = shift_s - {1'b0, dvsr_r};
        if (!trial_s[N]) begin
            step_rem_s  = trial_s[N-1:0];
            step_quot_s = {quot_r[N-2:0], 1'b1};
        end else begin
            step_rem_s  = shift_s[N-1:0];
            step_quot_s = {quot_r[N-2:0], 1'b0};
        end
        if (rem_sel_r) begin
            final_s = neg_rm_r ? neg2(step_rem_s) : step_rem_s;
        end else begin
            final_s = neg_q_r ? neg2(step_quot_s) : step_quot_s;
        end
    end

    // Next-state and datapath-update logic.
    always_comb begin
        state_n       = state_r;
        cnt_n         = cnt_r;
        rem_n         = rem_r;
        quot_n        = quot_r;
        dvsr_n        = dvsr_r;
        rem_sel_n     = rem_sel_r;
        neg_q_n       = neg_q_r;
        neg_rm_n      = neg_rm_r;
        special_n     = special_r;
        special_val_n = special_val_r;
        result_n      = result_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rem_n         = ZERO_N;
                    quot_n        = a_mag_s;
                    dvsr_n        = b_mag_s;
                    rem_sel_n     = op[1];
                    neg_q_n       = a_neg_s ^ b_neg_s;
                    neg_rm_n      = a_neg_s;
                    special_n     = special_s;
                    special_val_n = spec_val_s;
                    cnt_n         = CNT_ZERO;
`ifdef FAST_SPECIAL_EN
                    if (special_s) begin
                        state_n  = ST_DONE;
                        result_n = spec_val_s;
                    end else begin
                        state_n  = ST_RUN;
                    end
`else
                    state_n = ST_RUN;
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_n  = step_rem_s;
                quot_n = step_quot_s;
                cnt_n  = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    state_n  = ST_DONE;
                    cnt_n    = CNT_ZERO;
                    result_n = special_r ? special_val_r : final_s;
                end else begin
                    state_n  = ST_RUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            rem_r         <= ZERO_N;
            quot_r        <= ZERO_N;
            dvsr_r        <= ZERO_N;
            rem_sel_r     <= 1'b0;
            neg_q_r       <= 1'b0;
            neg_rm_r      <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= ZERO_N;
            result_r      <= ZERO_N;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            cnt_r         <= cnt_n;
            rem_r         <= rem_n;
            quot_r        <= quot_n;
            dvsr_r        <= dvsr_n;
            rem_sel_r     <= rem_sel_n;
            neg_q_r       <= neg_q_n;
            neg_rm_r      <= neg_rm_n;
            special_r     <= special_n;
            special_val_r <= special_val_n;
            result_r      <= result_n;
            busy_r        <= (state_n == ST_RUN);
            done_r        <= (state_n == ST_DONE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative RV32M divide/remainder unit: DIV, DIVU, REM, REMU.
- Sits in the execute stage beside the ALU.
- Its registered result is one input of the writeback-select multiplexer.
- Control holds the pipeline while busy and selects this result when done pulses.

Parameters:
N, 32, operand/result width in bits (even, >= 4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled on rising clk edge
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start
dividend  input  N  rs1 value; sampled with start
divisor  input  N  rs2 value; sampled with start
busy  output  1  high while an operation is iterating
done  output  1  one-cycle pulse: result valid
result  output  N  quotient or remainder, registered, held until next accepted start

Behaviour:
Reset:
- rst high: state=IDLE; busy=0, done=0, result=0, step counter=0, internal operand regs=0.
- Takes effect immediately, with no clock required.
- Reset mid-operation aborts the operation; no done is produced.

States: IDLE, RUN, DONE.
- busy = (state==RUN).
- done = (state==DONE).

Start acceptance:
- start is accepted in IDLE or DONE, so back-to-back operations are allowed.
- start is ignored in RUN; operands are not re-sampled.

IDLE/DONE + start:
- Latch op, dividend, divisor.
- Compute magnitudes:
  - Signed ops: two's-complement abs of each operand.
  - Unsigned ops: operands as-is.
- Record neg_q = sign(dividend) XOR sign(divisor), signed ops only.
- Record neg_r = sign(dividend), signed ops only.
- Clear partial remainder; counter=0; go to RUN.

IDLE/DONE, no start: go to (or stay in) IDLE; result holds.

RUN:
- One restoring-division step per cycle, MSB first.
- Step: shift {rem, quot} left by 1. Trial = rem - |divisor| at N+1-bit width. If the trial is non-negative, rem = trial and quot LSB = 1; else quot LSB = 0.
- After step N-1 (counter == N-1), go to DONE.
- On that same edge, load result:
  - DIV/DIVU: quot, negated if neg_q.
  - REM/REMU: rem, negated if neg_r.

Latency:
- Start sampled at edge k; done is high during the cycle after edge k+N.
- Fixed latency N cycles when FAST_SPECIAL_EN is not defined.

DONE: lasts exactly one cycle, then IDLE unless start is asserted.

Special cases (RISC-V defined, no trap):
- divisor==0: DIV/DIVU give all ones; REM/REMU give dividend unchanged.
- Signed overflow (dividend = 1<<(N-1), divisor = all ones, op DIV): result = dividend.
- Signed overflow with op REM: result = 0.
- Detection happens at start. Without the feature, these still take the full N cycles; the iteration is ignored and the special value is loaded at the transition to DONE.

Arithmetic:
- All negation is two's complement at N bits.
- The partial remainder is N+1 bits internally; only N bits are exported.

Optional Feature:
Macro: FAST_SPECIAL_EN
- Defined: on start with divisor==0 or signed overflow, go directly IDLE/DONE -> DONE and load the special result on the sampling edge. done is high in the next cycle (latency 1); busy never asserts.
- Defined: normal operations are unchanged (N cycles).
- Not defined: every operation takes exactly N cycles, giving deterministic latency for control.

Test Plan:
- DIVU 100 / 7 -> busy high 32 cycles; done one cycle after edge k+32; result=14. Then REMU 100 / 7 -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REM 7 / -2 -> 1.
- DIV 5 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. Latency 32 without macro, 1 with FAST_SPECIAL_EN.
- Start DIVU 9/3 with a second start (DIVU 50/5) pulsed at cycle 5 -> second start ignored; result=3. A start asserted during the DONE cycle (DIVU 50/5) -> accepted; next done gives 10.
- Start DIVU 1000/10, assert rst at cycle 10 (between clock edges) -> busy, done, result fall to 0 immediately; no done follows.
- Idle with start=0 for 20 cycles after a result of 14 -> result stays 14, done stays 0.
